// File: rtl/life_stepper_pkg.sv
// rtl/life_stepper_pkg.sv - board geometry and stepper state shared with swap control
package life_stepper_pkg;
  localparam int BOARD_SIZE        = 64;
  localparam int LOG_BOARD_SIZE    = $clog2(BOARD_SIZE);
  localparam int WORD_SIZE         = 16;
  localparam int LOG_WORD_SIZE     = $clog2(WORD_SIZE);
  localparam int WORDS_PER_ROW     = BOARD_SIZE / WORD_SIZE;
  localparam int LOG_WORDS_PER_ROW = LOG_BOARD_SIZE - LOG_WORD_SIZE;
  localparam int LOG_MAX_ADDR      = 2 * LOG_BOARD_SIZE - LOG_WORD_SIZE;

  typedef enum logic [2:0] {
    IDLE,
    PRIME_L,
    PRIME_C,
    FETCH_R,
    WRITE,
    DONE
  } stepper_state_t;
endpackage

// File: rtl/life_word_next.sv
// rtl/life_word_next.sv - next-generation word from a 3x3 window of packed words
module life_word_next #(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] up_l,
  input  logic [WORD_W-1:0] up_c,
  input  logic [WORD_W-1:0] up_r,
  input  logic [WORD_W-1:0] mid_l,
  input  logic [WORD_W-1:0] mid_c,
  input  logic [WORD_W-1:0] mid_r,
  input  logic [WORD_W-1:0] dn_l,
  input  logic [WORD_W-1:0] dn_c,
  input  logic [WORD_W-1:0] dn_r,
  output logic [WORD_W-1:0] next
);
  // Extended rows: bit 0 is the right word's MSB, top bit is the left word's LSB.
  logic [WORD_W+1:0] up_x, mid_x, dn_x;
  logic [3:0] n;

  assign up_x  = {up_l[0],  up_c,  up_r[WORD_W-1]};
  assign mid_x = {mid_l[0], mid_c, mid_r[WORD_W-1]};
  assign dn_x  = {dn_l[0],  dn_c,  dn_r[WORD_W-1]};

  always_comb begin
    next = '0;
    n    = '0;
    for (int i = 0; i < WORD_W; i++) begin
      n = {3'b0, up_x[i]} + {3'b0, up_x[i+1]} + {3'b0, up_x[i+2]}
        + {3'b0, mid_x[i]} + {3'b0, mid_x[i+2]}
        + {3'b0, dn_x[i]} + {3'b0, dn_x[i+1]} + {3'b0, dn_x[i+2]};
      next[i] = (n == 4'd3) | (mid_c[i] & (n == 4'd2));
    end
  end
endmodule

// File: rtl/life_stepper.sv
// rtl/life_stepper.sv - one Game-of-Life generation over a toroidal word-packed board
module life_stepper
  import life_stepper_pkg::*;
#(
  parameter int BOARD_W = BOARD_SIZE,
  parameter int WORD_W  = WORD_SIZE,
  parameter int ADDR_W  = $clog2(BOARD_W * BOARD_W / WORD_W)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [WORD_W-1:0] data_r_in,
  output logic [ADDR_W-1:0] addr_r_out,
  output logic [ADDR_W-1:0] addr_w_out,
  output logic [WORD_W-1:0] data_w_out,
  output logic              we_out,
  output logic              busy_out,
  output logic              done_out
);
  localparam int WPR = BOARD_W / WORD_W;
  localparam int YW  = $clog2(BOARD_W);
  localparam int XW  = (WPR > 1) ? $clog2(WPR) : 1;
  localparam logic [XW-1:0] W_MASK = XW'(WPR - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(BOARD_W - 1);

  stepper_state_t state, state_next;

  logic [YW-1:0] y;
  logic [XW-1:0] w;
  logic [1:0]    fr;
  logic [1:0]    slot;
  logic [WORD_W-1:0] left_w [3];
  logic [WORD_W-1:0] centre_w [3];
  logic [WORD_W-1:0] right_w [3];
  logic [WORD_W-1:0] next_word;

  logic [XW-1:0]     col_mod;
  logic [YW-1:0]     row_sel;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  assign slot = fr - 2'd1;

  // Fetch column is w-1 / w / w+1 depending on which window column is being filled.
  always_comb begin
    col_mod = w;
    case (state)
      PRIME_L: col_mod = (w - 1'b1) & W_MASK;
      FETCH_R: col_mod = (w + 1'b1) & W_MASK;
      default: col_mod = w & W_MASK;
    endcase
    row_sel = y - YW'(1) + YW'(fr);
    rd_addr = ADDR_W'(row_sel) * ADDR_W'(WPR) + ADDR_W'(col_mod);
    wr_addr = ADDR_W'(y) * ADDR_W'(WPR) + ADDR_W'(w);
  end

  life_word_next #(.WORD_W(WORD_W)) u_next (
    .up_l  (left_w[0]),
    .up_c  (centre_w[0]),
    .up_r  (right_w[0]),
    .mid_l (left_w[1]),
    .mid_c (centre_w[1]),
    .mid_r (right_w[1]),
    .dn_l  (left_w[2]),
    .dn_c  (centre_w[2]),
    .dn_r  (right_w[2]),
    .next  (next_word)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_in) state_next = PRIME_L;
      PRIME_L: if (fr == 2'd3) state_next = PRIME_C;
      PRIME_C: if (fr == 2'd3) state_next = FETCH_R;
      FETCH_R: if (fr == 2'd3) state_next = WRITE;
      WRITE: begin
        if (w == W_MASK) state_next = (y == Y_LAST) ? DONE : PRIME_L;
        else             state_next = FETCH_R;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    addr_r_out = '0;
    addr_w_out = '0;
    data_w_out = '0;
    we_out     = 1'b0;
    busy_out   = 1'b0;
    done_out   = 1'b0;
    case (state)
      PRIME_L, PRIME_C, FETCH_R: begin
        busy_out = 1'b1;
        if (fr != 2'd3) addr_r_out = rd_addr;
      end
      WRITE: begin
        busy_out   = 1'b1;
        we_out     = 1'b1;
        addr_w_out = wr_addr;
        data_w_out = next_word;
      end
      DONE:    done_out = 1'b1;
      default: ;
    endcase
  end

  // Read data lands one cycle after its address, so fetch step k captures row k-1.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      y  <= '0;
      w  <= '0;
      fr <= '0;
      for (int r = 0; r < 3; r++) begin
        left_w[r]   <= '0;
        centre_w[r] <= '0;
        right_w[r]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            y  <= '0;
            w  <= '0;
            fr <= '0;
          end
        end
        PRIME_L: begin
          fr <= fr + 2'd1;
          if (fr != 2'd0) left_w[slot] <= data_r_in;
        end
        PRIME_C: begin
          fr <= fr + 2'd1;
          if (fr != 2'd0) centre_w[slot] <= data_r_in;
        end
        FETCH_R: begin
          fr <= fr + 2'd1;
          if (fr != 2'd0) right_w[slot] <= data_r_in;
        end
        WRITE: begin
          for (int r = 0; r < 3; r++) begin
            left_w[r]   <= centre_w[r];
            centre_w[r] <= right_w[r];
          end
          w <= (w + 1'b1) & W_MASK;
          if (w == W_MASK) y <= y + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_life_stepper.sv
// tb/tb_life_stepper.sv - directed and random generations checked against a grid model
module tb_life_stepper;
  localparam int BW = 64;
  localparam int WW = 16;
  localparam int NW = BW * BW / WW;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic [15:0] data_r_in = '0;
  logic [7:0]  addr_r_out, addr_w_out;
  logic [15:0] data_w_out;
  logic        we_out, busy_out, done_out;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [2][NW];
  int          wcnt [NW];
  int          wtotal;
  int          cur = 0;
  logic [7:0]  prev_rd = '0;
  bit          g  [BW][BW];
  bit          gn [BW][BW];
  bit          fin;

  life_stepper #(.BOARD_W(BW), .WORD_W(WW)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .start_in   (start_in),
    .data_r_in  (data_r_in),
    .addr_r_out (addr_r_out),
    .addr_w_out (addr_w_out),
    .data_w_out (data_w_out),
    .we_out     (we_out),
    .busy_out   (busy_out),
    .done_out   (done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle of the 1-cycle-latency memory, serviced at the falling edge.
  task automatic tick();
    @(negedge clk_in);
    if (we_out) begin
      mem[1-cur][addr_w_out] = data_w_out;
      wcnt[addr_w_out]++;
      wtotal++;
    end
    data_r_in = mem[cur][prev_rd];
    prev_rd   = addr_r_out;
  endtask

  function automatic logic [15:0] pack_word(int a);
    logic [15:0] v;
    int yy, x0;
    yy = a / (BW / WW);
    x0 = (a % (BW / WW)) * WW;
    for (int b = 0; b < WW; b++) v[WW-1-b] = g[yy][x0+b];
    return v;
  endfunction

  function automatic bit dut_cell(int b, int x, int y);
    logic [15:0] v;
    v = mem[b][y * (BW / WW) + x / WW];
    return v[WW-1 - (x % WW)];
  endfunction

  task automatic clear_grid();
    for (int y = 0; y < BW; y++) for (int x = 0; x < BW; x++) g[y][x] = 0;
  endtask

  task automatic random_grid();
    for (int y = 0; y < BW; y++) for (int x = 0; x < BW; x++) g[y][x] = ($urandom % 3) == 0;
  endtask

  task automatic load_board();
    for (int a = 0; a < NW; a++) begin
      mem[cur][a]   = pack_word(a);
      mem[1-cur][a] = 16'hA5A5;
    end
  endtask

  task automatic model_step();
    int n;
    for (int y = 0; y < BW; y++)
      for (int x = 0; x < BW; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dy != 0 || dx != 0) n += int'(g[(y + dy + BW) % BW][(x + dx + BW) % BW]);
        gn[y][x] = (n == 3) || (g[y][x] && n == 2);
      end
    for (int y = 0; y < BW; y++) for (int x = 0; x < BW; x++) g[y][x] = gn[y][x];
  endtask

  task automatic check_board(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < NW; a++) if (mem[cur][a] !== pack_word(a)) bad++;
    check({tag, ":board_words_wrong"}, 32'(bad), 32'd0);
  endtask

  task automatic run_gen(input string tag, input int restart_at, input int reset_at,
                         input bit poke_done, output bit finished);
    int n, bad, dones;
    finished = 0;
    for (int a = 0; a < NW; a++) wcnt[a] = 0;
    wtotal   = 0;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    n = 1;
    check({tag, ":busy_rise"}, 32'(busy_out), 32'd1);
    while (n < 4000 && !done_out) begin
      if (n == reset_at) begin
        rst_in = 1'b1;
        #1;
        check({tag, ":rst_we"}, 32'(we_out), 32'd0);
        check({tag, ":rst_busy"}, 32'(busy_out), 32'd0);
        check({tag, ":rst_addr_r"}, 32'(addr_r_out), 32'd0);
        check({tag, ":rst_addr_w"}, 32'(addr_w_out), 32'd0);
        check({tag, ":rst_data_w"}, 32'(data_w_out), 32'd0);
        repeat (2) tick();
        rst_in = 1'b0;
        dones = 0;
        repeat (8) begin
          tick();
          if (done_out) dones++;
        end
        check({tag, ":abort_no_done"}, 32'(dones), 32'd0);
        check({tag, ":abort_idle"}, 32'(busy_out), 32'd0);
        return;
      end
      if (n == restart_at) start_in = 1'b1;
      tick();
      start_in = 1'b0;
      n++;
    end
    check({tag, ":done_cycle"}, 32'(n), 32'd1793);
    check({tag, ":write_total"}, 32'(wtotal), 32'(NW));
    bad = 0;
    for (int a = 0; a < NW; a++) if (wcnt[a] != 1) bad++;
    check({tag, ":addr_not_once"}, 32'(bad), 32'd0);
    if (poke_done) start_in = 1'b1;
    tick();
    start_in = 1'b0;
    check({tag, ":idle_after_done"}, 32'(busy_out), 32'd0);
    dones = 0;
    repeat (6) begin
      tick();
      if (done_out) dones++;
    end
    check({tag, ":single_done"}, 32'(dones), 32'd0);
    check({tag, ":still_idle"}, 32'(busy_out), 32'd0);
    cur = 1 - cur;
    finished = 1;
  endtask

  initial begin
    for (int b = 0; b < 2; b++) for (int a = 0; a < NW; a++) mem[b][a] = '0;
    repeat (3) tick();
    check("reset:we", 32'(we_out), 32'd0);
    check("reset:busy", 32'(busy_out), 32'd0);
    check("reset:done", 32'(done_out), 32'd0);
    check("reset:addr_r", 32'(addr_r_out), 32'd0);
    check("reset:addr_w", 32'(addr_w_out), 32'd0);
    check("reset:data_w", 32'(data_w_out), 32'd0);
    rst_in = 1'b0;
    tick();

    clear_grid();
    load_board();
    run_gen("empty", -1, -1, 0, fin);
    check("empty:finished", 32'(fin), 32'd1);
    model_step();
    check_board("empty");

    clear_grid();
    g[20][10] = 1; g[20][11] = 1; g[20][12] = 1;
    load_board();
    run_gen("blinker1", -1, -1, 0, fin);
    model_step();
    check_board("blinker1");
    check("blinker1:cell_11_19", 32'(dut_cell(cur, 11, 19)), 32'd1);
    check("blinker1:cell_11_21", 32'(dut_cell(cur, 11, 21)), 32'd1);
    check("blinker1:cell_10_20", 32'(dut_cell(cur, 10, 20)), 32'd0);
    run_gen("blinker2", -1, -1, 0, fin);
    model_step();
    check_board("blinker2");
    check("blinker2:cell_10_20", 32'(dut_cell(cur, 10, 20)), 32'd1);
    check("blinker2:cell_11_19", 32'(dut_cell(cur, 11, 19)), 32'd0);

    clear_grid();
    g[5][15] = 1; g[5][16] = 1; g[6][15] = 1; g[6][16] = 1;
    load_board();
    run_gen("block", -1, -1, 1, fin);
    model_step();
    check_board("block");
    check("block:cell_15_5", 32'(dut_cell(cur, 15, 5)), 32'd1);
    check("block:cell_16_6", 32'(dut_cell(cur, 16, 6)), 32'd1);
    check("block:cell_17_5", 32'(dut_cell(cur, 17, 5)), 32'd0);

    clear_grid();
    g[0][63] = 1; g[0][0] = 1; g[0][1] = 1;
    load_board();
    run_gen("wrap", -1, -1, 0, fin);
    model_step();
    check_board("wrap");
    check("wrap:cell_0_63", 32'(dut_cell(cur, 0, 63)), 32'd1);
    check("wrap:cell_0_1", 32'(dut_cell(cur, 0, 1)), 32'd1);
    check("wrap:cell_63_0", 32'(dut_cell(cur, 63, 0)), 32'd0);

    random_grid();
    load_board();
    run_gen("restart", 500, -1, 0, fin);
    check("restart:finished", 32'(fin), 32'd1);
    model_step();
    check_board("restart");

    random_grid();
    load_board();
    run_gen("abort", -1, 900, 0, fin);
    check("abort:finished", 32'(fin), 32'd0);
    load_board();
    run_gen("fresh", -1, -1, 0, fin);
    check("fresh:finished", 32'(fin), 32'd1);
    model_step();
    check_board("fresh");

    random_grid();
    load_board();
    for (int gen = 0; gen < 20; gen++) begin
      run_gen($sformatf("rand%0d", gen), -1, -1, 0, fin);
      model_step();
      check_board($sformatf("rand%0d", gen));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
